// File: rtl/iss_sched.sv
// Issue scheduler: register scoreboard plus writeback-slot reservation for three pipelined units.
// Latency: dec_ready is combinational on registered state; unit enables appear one cycle after issue.
// Backpressure: dec_ready drops on RAW/WAW hazard or a writeback-slot clash; optional macro ISS_SCHED_STATS_EN builds a stall counter.
module iss_sched #(
    parameter int LAT_A0 = 4,
    parameter int LAT_M0 = 6,
    parameter int LAT_L0 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [1:0]  dec_fu,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_users,
    input  logic        dec_usert,
    input  logic [4:0]  dec_rd,
    input  logic        dec_writereg,
    input  logic        wb_oper,
    input  logic [4:0]  wb_regdest,
    output logic        iss_a0_oper,
    output logic        iss_m0_oper,
    output logic        iss_l0_oper,
    output logic [4:0]  iss_regdest,
    output logic        iss_writereg,
    output logic [31:0] stall_count
);

    localparam logic [2:0] LA = 3'(LAT_A0);
    localparam logic [2:0] LM = 3'(LAT_M0);
    localparam logic [2:0] LL = 3'(LAT_L0);

    logic [31:0] pending_q, pending_d;
    logic [7:0]  rsv_q, rsv_d;
    logic        a0_q, a0_d, m0_q, m0_d, l0_q, l0_d;
    logic [4:0]  regdest_q, regdest_d;
    logic        writereg_q, writereg_d;

    logic [2:0]  lat;
    logic        uses_slot;
    logic        raw_haz, waw_haz, slot_haz;
    logic        issue;

    // Decode the target unit's latency and evaluate hazards against registered state.
    always_comb begin
        lat       = 3'd0;
        uses_slot = 1'b0;
        case (dec_fu)
            2'd0: begin lat = LA; uses_slot = 1'b1; end
            2'd1: begin lat = LM; uses_slot = 1'b1; end
            2'd2: begin lat = LL; uses_slot = 1'b1; end
            default: begin lat = 3'd0; uses_slot = 1'b0; end
        endcase
        // pending_q[0] is held at zero, so r0 never produces a hazard.
        raw_haz   = (dec_users & pending_q[dec_rs]) | (dec_usert & pending_q[dec_rt]);
        waw_haz   = dec_writereg & pending_q[dec_rd];
        slot_haz  = uses_slot & rsv_q[lat];
        // Nothing issues while reset is asserted.
        dec_ready = dec_valid & ~reset & ~raw_haz & ~waw_haz & ~slot_haz;
        issue     = dec_ready;
    end

    // Next-state for scoreboard, reservation shift register and issue outputs.
    always_comb begin
        rsv_d = rsv_q >> 1;
        if (issue && uses_slot) begin
            rsv_d[lat - 3'd1] = 1'b1;
        end
        pending_d = pending_q;
        if (wb_oper) begin
            pending_d[wb_regdest] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (issue && dec_writereg && (dec_rd != 5'd0)) begin
            pending_d[dec_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        a0_d       = issue & (dec_fu == 2'd0);
        m0_d       = issue & (dec_fu == 2'd1);
        l0_d       = issue & (dec_fu == 2'd2);
        regdest_d  = issue ? dec_rd : 5'd0;
        writereg_d = issue & dec_writereg;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q  <= '0;
            rsv_q      <= '0;
            a0_q       <= 1'b0;
            m0_q       <= 1'b0;
            l0_q       <= 1'b0;
            regdest_q  <= '0;
            writereg_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rsv_q      <= rsv_d;
            a0_q       <= a0_d;
            m0_q       <= m0_d;
            l0_q       <= l0_d;
            regdest_q  <= regdest_d;
            writereg_q <= writereg_d;
        end
    end

    assign iss_a0_oper  = a0_q;
    assign iss_m0_oper  = m0_q;
    assign iss_l0_oper  = l0_q;
    assign iss_regdest  = regdest_q;
    assign iss_writereg = writereg_q;

`ifdef ISS_SCHED_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Count every cycle an instruction is offered but held back; wraps naturally.
    always_comb begin
        stall_d = stall_q;
        if (dec_valid && !dec_ready) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_iss_sched.sv
// Testbench for iss_sched: randomized and directed stimulus against a transaction-level reference model.
// Latency: expected unit outputs are checked one cycle after each stimulus cycle.
// Backpressure: dec_ready is compared every cycle against the model's hazard decision.
module tb_iss_sched;

    localparam int LAT_A0 = 4;
    localparam int LAT_M0 = 6;
    localparam int LAT_L0 = 3;

    logic        clock;
    logic        reset;
    logic        dec_valid;
    logic        dec_ready;
    logic [1:0]  dec_fu;
    logic [4:0]  dec_rs, dec_rt;
    logic        dec_users, dec_usert;
    logic [4:0]  dec_rd;
    logic        dec_writereg;
    logic        wb_oper;
    logic [4:0]  wb_regdest;
    logic        iss_a0_oper, iss_m0_oper, iss_l0_oper;
    logic [4:0]  iss_regdest;
    logic        iss_writereg;
    logic [31:0] stall_count;

    iss_sched #(.LAT_A0(LAT_A0), .LAT_M0(LAT_M0), .LAT_L0(LAT_L0)) dut (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_fu(dec_fu),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_users(dec_users), .dec_usert(dec_usert),
        .dec_rd(dec_rd), .dec_writereg(dec_writereg),
        .wb_oper(wb_oper), .wb_regdest(wb_regdest),
        .iss_a0_oper(iss_a0_oper), .iss_m0_oper(iss_m0_oper), .iss_l0_oper(iss_l0_oper),
        .iss_regdest(iss_regdest), .iss_writereg(iss_writereg), .stall_count(stall_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Expected output of one cycle: {a0, m0, l0, regdest, writereg}.
    typedef struct {
        int         cyc;
        logic [8:0] v;
        logic [31:0] stall;
    } exp_t;

    // An instruction occupying a unit, with its absolute writeback cycle.
    typedef struct {
        int         wb_cyc;
        logic [4:0] rd;
        bit         wr;
    } fl_t;

    exp_t exp_q[$];
    fl_t  inflight[$];
    bit   pend[32];
    int unsigned mstall = 0;
    exp_t mon_e;

    // Monitor: compare DUT outputs against the expectation queued for this cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            if (exp_q[0].cyc < cyc_cnt) begin
                chk("iss_missed", 64'(exp_q[0].cyc), 64'(cyc_cnt));
                void'(exp_q.pop_front());
            end else if (exp_q[0].cyc == cyc_cnt) begin
                mon_e = exp_q.pop_front();
                chk("iss_out", {iss_a0_oper, iss_m0_oper, iss_l0_oper, iss_regdest, iss_writereg}, mon_e.v);
                chk("stall_count", stall_count, mon_e.stall);
            end
        end
    end

    function automatic int lat_of(input logic [1:0] fu);
        case (fu)
            2'd0: return LAT_A0;
            2'd1: return LAT_M0;
            2'd2: return LAT_L0;
            default: return 0;
        endcase
    endfunction

    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic step(input bit rst, input bit vld, input logic [1:0] fu,
                        input logic [4:0] rs, input logic [4:0] rt, input bit us, input bit ut,
                        input logic [4:0] rd, input bit wr, input bit spur, input logic [4:0] spur_rd,
                        output bit acc);
        bit wbv, slot, raw, waw, rdy;
        logic [4:0] wbr;
        int lat;
        exp_t e;
        wbv = 0;
        wbr = 5'd0;
        foreach (inflight[i])
            if (inflight[i].wb_cyc == cyc_cnt && inflight[i].wr) begin
                wbv = 1;
                wbr = inflight[i].rd;
            end
        for (int i = inflight.size() - 1; i >= 0; i--)
            if (inflight[i].wb_cyc <= cyc_cnt) inflight.delete(i);
        if (!wbv && spur) begin
            wbv = 1;
            wbr = spur_rd;
        end
        reset = rst; dec_valid = vld; dec_fu = fu; dec_rs = rs; dec_rt = rt;
        dec_users = us; dec_usert = ut; dec_rd = rd; dec_writereg = wr;
        wb_oper = wbv; wb_regdest = wbr;
        #1;
        lat = lat_of(fu);
        slot = 0;
        if (fu != 2'd3)
            foreach (inflight[i])
                if (inflight[i].wb_cyc == cyc_cnt + lat) slot = 1;
        raw = (us && rs != 0 && pend[rs]) || (ut && rt != 0 && pend[rt]);
        waw = wr && rd != 0 && pend[rd];
        rdy = vld && !rst && !raw && !waw && !slot;
        chk("dec_ready", dec_ready, rdy);
        acc = rdy;
        e.cyc = cyc_cnt + 1;
        e.v = 9'd0;
        if (rst) begin
            foreach (pend[i]) pend[i] = 0;
            inflight.delete();
            mstall = 0;
        end else begin
`ifdef ISS_SCHED_STATS_EN
            if (vld && !rdy) mstall++;
`endif
            if (wbv) pend[wbr] = 0;
            if (rdy && wr && rd != 0) pend[rd] = 1;
            if (rdy && fu != 2'd3) begin
                fl_t f;
                f.wb_cyc = cyc_cnt + lat;
                f.rd = rd;
                f.wr = wr;
                inflight.push_back(f);
            end
            if (rdy) e.v = {fu == 2'd0, fu == 2'd1, fu == 2'd2, rd, wr};
        end
        e.stall = mstall;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, a);
    endtask

    task automatic instr(input logic [1:0] fu, input logic [4:0] rs, input logic [4:0] rt,
                         input bit us, input bit ut, input logic [4:0] rd, input bit wr, output bit a);
        step(0, 1, fu, rs, rt, us, ut, rd, wr, 0, 5'd0, a);
    endtask

    // Hold an instruction until accepted, counting stalled cycles.
    task automatic present(input logic [1:0] fu, input logic [4:0] rs, input logic [4:0] rt,
                           input bit us, input bit ut, input logic [4:0] rd, input bit wr,
                           output int stalls);
        bit a;
        a = 0;
        stalls = 0;
        for (int k = 0; k < 30 && !a; k++) begin
            instr(fu, rs, rt, us, ut, rd, wr, a);
            if (!a) stalls++;
        end
        if (!a) chk("present_timeout", 64'(a), 64'd1);
    endtask

    initial begin
        bit a;
        int st;
        reset = 1; dec_valid = 0; dec_fu = 0; dec_rs = 0; dec_rt = 0; dec_users = 0;
        dec_usert = 0; dec_rd = 0; dec_writereg = 0; wb_oper = 0; wb_regdest = 0;
        foreach (pend[i]) pend[i] = 0;
        @(posedge clock);
        #1;
        // Reset with an instruction offered: nothing may issue.
        step(1, 1, 2'd0, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 5'd0, a);
        step(1, 1, 2'd0, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 5'd0, a);

        // A0 writes r5, dependent reader stalls until the writeback has cleared.
        instr(2'd0, 5'd0, 5'd0, 0, 0, 5'd5, 1, a);
        chk("a0_issue", 64'(a), 64'd1);
        present(2'd0, 5'd5, 5'd0, 1, 0, 5'd6, 1, st);
        chk("raw_stalls", 64'(st), 64'd4);
`ifdef ISS_SCHED_STATS_EN
        chk("raw_stall_count", stall_count, 32'd4);
`endif
        idle(10);

        // A0 reservation at slot t+4 blocks an L0 (latency 3) one cycle later for one cycle.
        instr(2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, a);
        present(2'd2, 5'd0, 5'd0, 0, 0, 5'd0, 0, st);
        chk("l0_slot_stalls", 64'(st), 64'd1);
        idle(10);

        // M0 then A0 two cycles later target the same writeback slot.
        instr(2'd1, 5'd0, 5'd0, 0, 0, 5'd0, 0, a);
        idle(1);
        present(2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, st);
        chk("m0_a0_slot_stalls", 64'(st), 64'd1);
        idle(10);

        // Same-cycle set and clear of r7: set wins, reader stalls.
        step(0, 1, 2'd0, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 5'd7, a);
        chk("setclr_issue", 64'(a), 64'd1);
        instr(2'd3, 5'd7, 5'd0, 1, 0, 5'd0, 0, a);
        chk("setclr_reader_stall", 64'(a), 64'd0);
        present(2'd3, 5'd7, 5'd0, 1, 0, 5'd0, 0, st);
        chk("setclr_wait", 64'(st), 64'd3);
        idle(10);

        // r0 is never pending: back-to-back r0 readers do not stall.
        instr(2'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, a);
        st = 0;
        for (int k = 0; k < 4; k++) begin
            instr(2'd3, 5'd0, 5'd0, 1, 1, 5'd0, 0, a);
            if (!a) st++;
        end
        chk("r0_reader_stalls", 64'(st), 64'd0);
        idle(10);

        // Reset mid-stall, then a fresh A0 issues immediately.
        instr(2'd1, 5'd0, 5'd0, 0, 0, 5'd9, 1, a);
        instr(2'd3, 5'd9, 5'd0, 1, 0, 5'd0, 0, a);
        chk("pre_rst_stall", 64'(a), 64'd0);
        step(1, 1, 2'd3, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 5'd0, a);
        chk("rst_noissue", 64'(a), 64'd0);
        instr(2'd0, 5'd0, 5'd0, 0, 0, 5'd3, 1, a);
        chk("post_rst_a0", 64'(a), 64'd1);
        instr(2'd3, 5'd9, 5'd0, 1, 0, 5'd0, 0, a);
        chk("post_rst_r9_free", 64'(a), 64'd1);
        idle(10);

        // Randomized traffic with stray writebacks and occasional reset.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] fu;
            bit wr;
            fu = 2'($urandom_range(0, 3));
            wr = (fu != 2'd3) ? bit'($urandom_range(0, 1)) : 1'b0;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, fu,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), wr,
                 $urandom_range(0, 15) == 0, 5'($urandom_range(0, 7)), a);
        end
        idle(3);
        repeat (2) @(posedge clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
